// File: rtl/master_bus_requester_if.sv
// Handshake bundle between the master datapath / arbiter and the bus requester.
// The master modport is the requester's view; the slave modport is the
// environment's view (datapath plus arbiter) driving the inputs.
interface master_bus_requester_if;
  logic       txn_start;
  logic [1:0] txn_slave;
  logic       txn_complete;
  logic       ARB_BUSY;
  logic       BUS_BUSY;
  logic       M_GRANT;
  logic       M_RQST;
  logic       M_slave_SEL;
  logic       tx_done;
  logic       bus_owned;
  logic       txn_busy;
  logic       txn_ok;
  logic       txn_err;

  modport master (
    input  txn_start, txn_slave, txn_complete, ARB_BUSY, BUS_BUSY, M_GRANT,
    output M_RQST, M_slave_SEL, tx_done, bus_owned, txn_busy, txn_ok, txn_err
  );

  modport slave (
    output txn_start, txn_slave, txn_complete, ARB_BUSY, BUS_BUSY, M_GRANT,
    input  M_RQST, M_slave_SEL, tx_done, bus_owned, txn_busy, txn_ok, txn_err
  );
endinterface

// File: rtl/master_bus_requester.sv
// Master-side bus requester: raises the request, shifts the 2-bit slave
// address to the arbiter serially (bit 0 then bit 1), waits for grant,
// follows ownership through split pauses and signals end of transaction.
// Every output is a register updated alongside the state.
module master_bus_requester #(
  parameter int GRANT_TIMEOUT = 255,
  parameter int SPLIT_TIMEOUT = 1023
) (
  input  logic                   MASTER_CLK,
  input  logic                   MASTER_RST,
  master_bus_requester_if.master bus
);

  localparam logic [7:0] GRANT_LIMIT = 8'(GRANT_TIMEOUT);
  localparam logic [9:0] SPLIT_LIMIT = 10'(SPLIT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ADDR0,
    REQ_ADDR1,
    WAIT_GRANT,
    OWN,
    SPLIT_WAIT,
    FINISH
  } state_t;

  state_t     state;
  logic [1:0] slave_addr;
  logic [7:0] grant_cnt;
  logic [9:0] split_cnt;
  logic [7:0] grant_cnt_next;
  logic [9:0] split_cnt_next;

  // Saturating increments; a timeout fires when the next value hits the limit.
  always_comb begin
    grant_cnt_next = (grant_cnt == GRANT_LIMIT) ? grant_cnt : grant_cnt + 8'd1;
    split_cnt_next = (split_cnt == SPLIT_LIMIT) ? split_cnt : split_cnt + 10'd1;
  end

  // Transaction state machine with registered outputs; single-cycle pulses default low.
  always_ff @(posedge MASTER_CLK or posedge MASTER_RST) begin
    if (MASTER_RST) begin
      state           <= IDLE;
      slave_addr      <= 2'b00;
      grant_cnt       <= 8'd0;
      split_cnt       <= 10'd0;
      bus.M_RQST      <= 1'b0;
      bus.M_slave_SEL <= 1'b0;
      bus.tx_done     <= 1'b0;
      bus.bus_owned   <= 1'b0;
      bus.txn_busy    <= 1'b0;
      bus.txn_ok      <= 1'b0;
      bus.txn_err     <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      bus.txn_ok  <= 1'b0;
      bus.txn_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.txn_start) begin
            slave_addr      <= bus.txn_slave;
            bus.txn_busy    <= 1'b1;
            bus.M_RQST      <= 1'b1;
            bus.M_slave_SEL <= bus.txn_slave[0];
            state           <= REQ_ADDR0;
          end
        end
        REQ_ADDR0: begin
          if (!bus.ARB_BUSY && !bus.BUS_BUSY) begin
            bus.M_slave_SEL <= slave_addr[1];
            state           <= REQ_ADDR1;
          end else begin
            bus.M_slave_SEL <= slave_addr[0];
          end
        end
        REQ_ADDR1: begin
          bus.M_slave_SEL <= 1'b0;
          grant_cnt       <= 8'd0;
          state           <= WAIT_GRANT;
        end
        WAIT_GRANT: begin
          if (bus.M_GRANT) begin
            bus.M_RQST    <= 1'b0;
            bus.bus_owned <= 1'b1;
            state         <= OWN;
          end else if (grant_cnt_next == GRANT_LIMIT) begin
            grant_cnt    <= grant_cnt_next;
            bus.M_RQST   <= 1'b0;
            bus.txn_err  <= 1'b1;
            bus.txn_busy <= 1'b0;
            state        <= IDLE;
          end else begin
            grant_cnt <= grant_cnt_next;
          end
        end
        OWN: begin
          if (bus.txn_complete) begin
            bus.tx_done   <= 1'b1;
            bus.bus_owned <= 1'b0;
            state         <= FINISH;
          end else if (!bus.M_GRANT) begin
            bus.bus_owned <= 1'b0;
            split_cnt     <= 10'd0;
            state         <= SPLIT_WAIT;
          end else begin
            bus.bus_owned <= 1'b1;
          end
        end
        SPLIT_WAIT: begin
          if (bus.M_GRANT) begin
            bus.bus_owned <= 1'b1;
            state         <= OWN;
          end else if (split_cnt_next == SPLIT_LIMIT) begin
            split_cnt    <= split_cnt_next;
            bus.txn_err  <= 1'b1;
            bus.txn_busy <= 1'b0;
            state        <= IDLE;
          end else begin
            split_cnt <= split_cnt_next;
          end
        end
        FINISH: begin
          bus.txn_ok   <= 1'b1;
          bus.txn_busy <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/master_bus_requester.md
Name: master_bus_requester

Overview:
- Master-side end of the arbitration interface on the system bus.
- Takes a transaction request from the master datapath and raises the bus request toward the arbiter.
- Shifts the 2-bit slave address to the arbiter serially, bit 0 then bit 1, on the single select line.
- Waits for grant, tracks bus ownership (including split pauses and resumes), and issues the end-of-transaction pulse back to the arbiter.

Parameters:
- GRANT_TIMEOUT, 255: max cycles in WAIT_GRANT before abort; 8-bit counter.
- SPLIT_TIMEOUT, 1023: max cycles in SPLIT_WAIT before abort; 10-bit counter.

Ports:
- MASTER_CLK  in  1  system clock.
- MASTER_RST  in  1  asynchronous active-high reset.
- txn_start  in  1  datapath pulse: begin a transaction; sampled only in IDLE.
- txn_slave  in  2  target slave address; captured with txn_start.
- txn_complete  in  1  datapath: last beat of transaction done; sampled only in OWN.
- ARB_BUSY  in  1  arbiter busy flag.
- BUS_BUSY  in  1  bus busy flag.
- M_GRANT  in  1  grant from arbiter for this master.
- M_RQST  out  1  bus request to arbiter.
- M_slave_SEL  out  1  serial slave address to arbiter.
- tx_done  out  1  1-cycle pulse to arbiter at end of owned transaction.
- bus_owned  out  1  datapath may drive the bus this cycle.
- txn_busy  out  1  high from txn_start accept until DONE/ABORT.
- txn_ok  out  1  1-cycle pulse on normal completion.
- txn_err  out  1  1-cycle pulse on timeout abort.

Behaviour:
- Reset (async, MASTER_RST=1):
  - State = IDLE.
  - All outputs 0, counters 0, latched slave address 00.
  - Reset mid-operation drops M_RQST immediately, with no tx_done.
- States: IDLE, REQ_ADDR0, REQ_ADDR1, WAIT_GRANT, OWN, SPLIT_WAIT, FINISH. All outputs are registered.
- IDLE:
  - txn_start=1: latch txn_slave, txn_busy<=1, go REQ_ADDR0.
  - Otherwise stay.
- REQ_ADDR0: M_RQST=1, M_slave_SEL=slave[0].
  - ARB_BUSY=0 and BUS_BUSY=0 in this cycle: the arbiter samples bit 0 at this edge; go REQ_ADDR1.
  - Else hold both outputs and stay (no timeout here).
- REQ_ADDR1: M_RQST=1, M_slave_SEL=slave[1]; unconditionally go WAIT_GRANT next edge.
- WAIT_GRANT: M_RQST=1, M_slave_SEL=0, grant counter increments each cycle.
  - M_GRANT=1: go OWN.
  - Counter reaches GRANT_TIMEOUT with no grant: drop M_RQST, pulse txn_err, go IDLE, txn_busy<=0.
- OWN: M_RQST=0 (dropped so the arbiter does not re-arbitrate this master on release); bus_owned=M_GRANT.
  - txn_complete=1: tx_done pulse (1 cycle), go FINISH. Completion takes priority if it coincides with a grant drop.
  - M_GRANT falls without txn_complete (split): bus_owned=0, clear split counter, go SPLIT_WAIT.
- SPLIT_WAIT: M_RQST=0, bus_owned=0, split counter increments.
  - M_GRANT returns to 1: go OWN; bus_owned=1 from the next cycle.
  - Counter reaches SPLIT_TIMEOUT: pulse txn_err, go IDLE. No tx_done is issued, because the arbiter still holds the split context.
  - txn_complete is ignored here.
- FINISH: txn_ok pulse, txn_busy<=0, go IDLE.
- The earliest new txn_start accepted is the IDLE cycle after FINISH; txn_start in any other state is ignored.
- Bit order is fixed: bit 0 first, then bit 1, each on one cycle, back-to-back.
- Counters saturate at the parameter value and clear on every entry to WAIT_GRANT or SPLIT_WAIT.

Test Plan:
- Idle bus, txn_start with txn_slave=2'b10:
  - M_RQST rises; M_slave_SEL=0 then 1 on consecutive cycles.
  - Grant driven 2 cycles later → bus_owned=1.
  - txn_complete → tx_done pulse, then txn_ok pulse.
- BUS_BUSY=1 during REQ_ADDR0 for 5 cycles, txn_slave=2'b01:
  - M_slave_SEL holds 1 and M_RQST holds high.
  - REQ_ADDR1 is entered only on the first cycle with both flags low.
- Never grant:
  - txn_err pulses exactly GRANT_TIMEOUT cycles after WAIT_GRANT entry.
  - M_RQST drops and txn_busy=0 at the same time.
- Split: drop M_GRANT for 20 cycles while in OWN, then re-raise:
  - bus_owned=0 for the gap, and no tx_done during it.
  - Ownership resumes; a later txn_complete gives a normal tx_done and txn_ok.
- Split never resumes: txn_err after SPLIT_TIMEOUT cycles, and no tx_done.
- Assert MASTER_RST during WAIT_GRANT: all outputs 0 immediately, state IDLE; next txn_start is accepted normally.
